// File: rtl/ifu_prefetch_if.sv
// Prefetch-unit bus bundle: redirect input, SRAM read port and decode handshake.
// master = surrounding pipeline/SRAM side, slave = ifu_prefetch.
interface ifu_prefetch_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [14:0] mem_addr_o;
    logic        mem_ren_o;
    logic [31:0] mem_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    modport master (
        output flush_i, flush_pc_i, mem_data_i, inst_ready_i,
        input  mem_addr_o, mem_ren_o, inst_valid_o, inst_o, inst_pc_o
    );

    modport slave (
        input  flush_i, flush_pc_i, mem_data_i, inst_ready_i,
        output mem_addr_o, mem_ren_o, inst_valid_o, inst_o, inst_pc_o
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: owns the fetch PC, reads the 1-cycle SRAM, buffers {instr, pc} for decode.
// Optional IFU_PREFETCH_BYPASS_EN: an empty buffer forwards the SRAM response to decode in the same cycle.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ifu_prefetch_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]      pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic             discard;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];

    logic        issue;
    logic        rsp_valid;
    logic        head_valid;
    logic        take;
    logic        push;
    logic        pop;
    logic [31:0] target_pc;

    // Issue/capture/handshake decode; a same-cycle pop never frees a slot for issue.
    always_comb begin
        target_pc  = bus.flush_pc_i & 32'hFFFF_FFFC;
        issue      = !rst_i && !bus.flush_i &&
                     ((OCC_W'(count) + OCC_W'(inflight)) < OCC_W'(FIFO_DEPTH));
        rsp_valid  = inflight && !discard && !bus.flush_i && !rst_i;
        head_valid = (count != '0) && !rst_i;

        bus.mem_ren_o    = issue;
        bus.mem_addr_o   = rst_i ? RESET_PC_ALIGNED[16:2] : pc[16:2];
        bus.inst_valid_o = 1'b0;
        bus.inst_o       = 32'h0;
        bus.inst_pc_o    = 32'h0;

        if (head_valid) begin
            bus.inst_valid_o = 1'b1;
            bus.inst_o       = fifo_inst[rd_ptr];
            bus.inst_pc_o    = fifo_pc[rd_ptr];
        end
`ifdef IFU_PREFETCH_BYPASS_EN
        else if (rsp_valid) begin
            bus.inst_valid_o = 1'b1;
            bus.inst_o       = bus.mem_data_i;
            bus.inst_pc_o    = inflight_pc;
        end
`endif

        take = bus.inst_valid_o && bus.inst_ready_i && !bus.flush_i;
        pop  = take && head_valid;
`ifdef IFU_PREFETCH_BYPASS_EN
        push = rsp_valid && !(take && !head_valid);
`else
        push = rsp_valid;
`endif
    end

    // PC, in-flight tracking and buffer occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc          <= RESET_PC_ALIGNED;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            discard     <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            // A flush always masks the coincident response, so no stale beat survives it.
            if (bus.flush_i || inflight) begin
                discard <= 1'b0;
            end
            if (bus.flush_i) begin
                pc     <= target_pc;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (issue) begin
                    pc <= pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Buffer storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.mem_data_i;
            fifo_pc[wr_ptr]   <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: directed PC streams, stall, flush, wrap and mid-stream reset.
module tb_ifu_prefetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 4;
`ifdef IFU_PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   xfer_cnt = 0;
    int   x0;
    exp_t exp_q[$];

    ifu_prefetch_if bus ();

    ifu_prefetch #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return 32'h5A00_0000 | {17'h0, a};
    endfunction

    function automatic exp_t mk(input logic [31:0] p);
        exp_t e;
        e.pc   = p;
        e.inst = mem_word(p[16:2]);
        return e;
    endfunction

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(start + 32'(4 * i)));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // SRAM model: data for the address read in the previous cycle, garbage otherwise.
    initial begin
        logic        r;
        logic [14:0] a;
        bus.mem_data_i = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            r = bus.mem_ren_o;
            a = bus.mem_addr_o;
            @(posedge clk);
            #1;
            bus.mem_data_i = r ? mem_word(a) : 32'hDEAD_BEEF;
        end
    end

    // Monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid_o && bus.inst_ready_i && !bus.flush_i) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_xfer: got pc %h inst %h, none expected", bus.inst_pc_o, bus.inst_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_pc", bus.inst_pc_o, e.pc);
                chk("xfer_inst", bus.inst_o, e.inst);
            end
        end
        if (!rst && dut.push) chk("push_has_room", 32'(32'(dut.count) < DEPTH), 32'd1);
    end

    initial begin
        bus.flush_i      = 1'b0;
        bus.flush_pc_i   = 32'h0;
        bus.inst_ready_i = 1'b1;
        push_stream(RST_PC, 40);

        // Reset values
        repeat (3) tick;
        sample;
        chk("rst_ren", 32'(bus.mem_ren_o), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr_o), 32'h40);
        chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_inst", bus.inst_o, 32'h0);
        chk("rst_inst_pc", bus.inst_pc_o, 32'h0);

        // Release: cycle 0 issues RESET_PC
        tick; rst = 1'b0;
        sample;
        chk("c0_ren", 32'(bus.mem_ren_o), 32'd1);
        chk("c0_addr", 32'(bus.mem_addr_o), 32'h40);
        tick; sample;
        chk("c1_addr", 32'(bus.mem_addr_o), 32'h41);
        chk("c1_valid", 32'(bus.inst_valid_o), 32'(LAT == 1));
        tick; sample;
        chk("c2_addr", 32'(bus.mem_addr_o), 32'h42);
        chk("c2_valid", 32'(bus.inst_valid_o), 32'd1);
        chk("c2_inst_pc", bus.inst_pc_o, RST_PC + 32'(4 * (2 - LAT)));

        // Steady streaming: one per cycle
        tick; x0 = xfer_cnt;
        repeat (6) sample;
        #1;
        chk("stream_rate", 32'(xfer_cnt - x0), 32'd6);

        // Decode stall fills the buffer and stops issue
        tick; bus.inst_ready_i = 1'b0;
        repeat (10) tick;
        sample;
        chk("stall_ren", 32'(bus.mem_ren_o), 32'd0);
        chk("stall_count", 32'(dut.count), 32'(DEPTH));
        chk("stall_valid", 32'(bus.inst_valid_o), 32'd1);
        tick; bus.inst_ready_i = 1'b1; x0 = xfer_cnt;
        repeat (10) sample;
        #1;
        chk("resume_rate", 32'(xfer_cnt - x0), 32'd10);

        // Flush with a read in flight and a non-empty buffer
        tick; bus.inst_ready_i = 1'b0;
        tick;
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h0000_0203;
        exp_q.delete();
        push_stream(32'h200, 20);
        sample;
        chk("flush_pre_inflight", 32'(dut.inflight), 32'd1);
        chk("flush_no_issue", 32'(bus.mem_ren_o), 32'd0);
        tick; bus.flush_i = 1'b0; bus.inst_ready_i = 1'b1;
        sample;
        chk("f1_ren", 32'(bus.mem_ren_o), 32'd1);
        chk("f1_addr", 32'(bus.mem_addr_o), 32'h80);
        chk("f1_valid", 32'(bus.inst_valid_o), 32'd0);
        tick; sample;
        chk("f2_valid", 32'(bus.inst_valid_o), 32'(LAT == 1));
        tick; sample;
        chk("f3_valid", 32'(bus.inst_valid_o), 32'd1);
        chk("f3_inst_pc", bus.inst_pc_o, 32'h200 + 32'(4 * (3 - LAT - 1)));

        // Flush coinciding with a pop
        repeat (3) tick;
        tick;
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h0000_1000;
        exp_q.delete();
        push_stream(32'h1000, 20);
        tick; bus.flush_i = 1'b0;
        sample;
        chk("fp1_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("fp1_addr", 32'(bus.mem_addr_o), 32'h400);
        tick; sample;
        tick; sample;
        chk("fp3_inst_pc", bus.inst_pc_o, 32'h1000 + 32'(4 * (3 - LAT - 1)));

        // Held flush then PC wrap through zero
        repeat (3) tick;
        tick;
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h1234_5678;
        exp_q.delete();
        sample;
        chk("held1_ren", 32'(bus.mem_ren_o), 32'd0);
        tick;
        bus.flush_pc_i = 32'hFFFF_FFF8;
        push_stream(32'hFFFF_FFF8, 20);
        sample;
        chk("held2_ren", 32'(bus.mem_ren_o), 32'd0);
        tick; bus.flush_i = 1'b0;
        sample;
        chk("wrap_addr0", 32'(bus.mem_addr_o), 32'h7FFE);
        tick; sample;
        chk("wrap_addr1", 32'(bus.mem_addr_o), 32'h7FFF);
        tick; sample;
        chk("wrap_addr2", 32'(bus.mem_addr_o), 32'h0);
        chk("wrap_valid", 32'(bus.inst_valid_o), 32'd1);
        repeat (4) tick;

        // Mid-stream reset with a full buffer
        tick; bus.inst_ready_i = 1'b0;
        repeat (8) tick;
        sample;
        chk("full_before_rst", 32'(dut.count), 32'(DEPTH));
        tick; rst = 1'b1;
        exp_q.delete();
        push_stream(RST_PC, 20);
        sample;
        chk("rst_mid_ren", 32'(bus.mem_ren_o), 32'd0);
        tick; rst = 1'b0; bus.inst_ready_i = 1'b1;
        sample;
        chk("post_rst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("post_rst_inst", bus.inst_o, 32'h0);
        chk("post_rst_inst_pc", bus.inst_pc_o, 32'h0);
        chk("post_rst_addr", 32'(bus.mem_addr_o), 32'h40);
        chk("post_rst_ren", 32'(bus.mem_ren_o), 32'd1);
        chk("post_rst_count", 32'(dut.count), 32'd0);
        tick; x0 = xfer_cnt;
        repeat (8) sample;
        #1;
        chk("refetch_rate", 32'(xfer_cnt - x0), 32'(9 - LAT));

        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
